// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control between execute and a word-addressed data
// memory. Converts byte addresses to word indices, extracts and extends
// byte/half loads, and merges SB/SH into the memory word with a
// read-modify-write. Rejected requests get a one-cycle error response.
module lsu_ctrl #(
  parameter int unsigned MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic        d_r_en,
  output logic        d_w_en,
  output logic [31:0] d_add,
  output logic [31:0] data_in,
  input  logic [31:0] d_out
);

  localparam logic [31:0] MW = 32'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, LD_RD, LD_RSP, ST_WR, RMW_RD, RMW_WR} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;

  logic        accept, illegal, misal, oor, err_any;
  logic [1:0]  cause;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val, merged, word_idx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign word_idx  = {2'b00, addr_q[31:2]};

  // Classify the incoming request; illegal beats misaligned beats range.
  always_comb begin
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_we && req_funct3[2]);
    misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    oor     = ({2'b00, req_addr[31:2]} >= MW);
    err_any = illegal || misal || oor;
    if (illegal)    cause = 2'b11;
    else if (misal) cause = 2'b01;
    else if (oor)   cause = 2'b10;
    else            cause = 2'b00;
  end

  // Load lane select/extension and store merge, both straight off d_out.
  always_comb begin
    lane_b = d_out[{addr_q[1:0], 3'b000} +: 8];
    lane_h = d_out[{addr_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   ld_val = {{24{lane_b[7] & ~f3_q[2]}}, lane_b};
      2'b01:   ld_val = {{16{lane_h[15] & ~f3_q[2]}}, lane_h};
      default: ld_val = d_out;
    endcase
    merged = d_out;
    if (f3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Next state and memory strobes; strobes decode from state only so a
  // reset drops them without waiting for a clock.
  always_comb begin
    state_nxt = state;
    d_r_en    = 1'b0;
    d_w_en    = 1'b0;
    d_add     = '0;
    data_in   = '0;
    case (state)
      IDLE: begin
        if (accept && !err_any) begin
          if (!req_we)                      state_nxt = LD_RD;
          else if (req_funct3[1:0] == 2'b10) state_nxt = ST_WR;
          else                              state_nxt = RMW_RD;
        end
      end
      LD_RD: begin
        d_r_en    = 1'b1;
        d_add     = word_idx;
        state_nxt = LD_RSP;
      end
      LD_RSP: state_nxt = IDLE;
      ST_WR: begin
        d_w_en    = 1'b1;
        d_add     = word_idx;
        data_in   = wdata_q;
        state_nxt = IDLE;
      end
      RMW_RD: begin
        d_r_en    = 1'b1;
        d_add     = word_idx;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        d_w_en    = 1'b1;
        d_add     = word_idx;
        data_in   = merged;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Hold the accepted request for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response pulse; payload holds until the next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_cause <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept && err_any) begin
        resp_valid <= 1'b1;
        resp_rdata <= '0;
        resp_err   <= 1'b1;
        resp_cause <= cause;
      end else if (state == LD_RSP) begin
        resp_valid <= 1'b1;
        resp_rdata <= we_q ? 32'h0 : ld_val;
        resp_err   <= 1'b0;
        resp_cause <= 2'b00;
      end else if (state == ST_WR || state == RMW_WR) begin
        resp_valid <= 1'b1;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
        resp_cause <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: behavioural memory on the d_* port, and a
// byte-array reference model that predicts each response from the RV32 rules.
module tb_lsu_ctrl;
  localparam int MW = 100;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, d_r_en, d_w_en;
  logic [31:0] resp_rdata, d_add, data_in;
  logic [1:0]  resp_cause;
  logic [31:0] d_out = '0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_cause(resp_cause), .d_r_en(d_r_en), .d_w_en(d_w_en),
    .d_add(d_add), .data_in(data_in), .d_out(d_out)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Data memory: registered read, write on the edge.
  logic [31:0] mem [MW];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
    end else begin
      if (d_w_en && d_add < 32'(MW)) mem[d_add[6:0]] <= data_in;
      if (d_r_en && d_add < 32'(MW)) d_out <= mem[d_add[6:0]];
    end
  end

  int excl_viol = 0;
  always @(negedge clk) if (d_r_en && d_w_en) excl_viol++;

  // Reference model: flat little-endian byte memory.
  logic [7:0] rmem [4*MW];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [1:0] cause,
                       output logic [31:0] rd);
    int nb;
    logic [31:0] v;
    cause = 2'b00;
    rd    = '0;
    lat   = 1;
    if (f3 == 3 || f3 == 6 || f3 == 7 || (we && f3[2])) cause = 2'b11;
    else if ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00)) cause = 2'b01;
    else if ((a >> 2) >= 32'(MW)) cause = 2'b10;
    if (cause != 2'b00) return;
    nb = 1 << f3[1:0];
    if (we) begin
      for (int i = 0; i < nb; i++) rmem[int'(a) + i] = wd[8*i +: 8];
      lat = (nb == 4) ? 2 : 3;
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = rmem[int'(a) + i];
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd  = v;
      lat = 3;
    end
  endtask

  logic [31:0] last_rd, last_add1;
  logic [1:0]  last_cause;
  logic        last_wen1;

  // Issue one request from IDLE and check the response against the model.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    int elat, cyc;
    logic [1:0] ec;
    logic [31:0] erd;
    bit got, saw_en;
    model(we, f3, a, wd, elat, ec, erd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    cyc = 0; got = 0; saw_en = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 1'b0;
        last_add1 = d_add;
        last_wen1 = d_w_en;
      end
      if (d_r_en || d_w_en) saw_en = 1;
      if (resp_valid) begin
        got        = 1;
        last_rd    = resp_rdata;
        last_cause = resp_cause;
        chk({tag, " lat"}, 32'(cyc), 32'(elat));
        chk({tag, " err"}, {31'b0, resp_err}, {31'b0, ec != 2'b00});
        chk({tag, " cause"}, {30'b0, resp_cause}, {30'b0, ec});
        chk({tag, " rdata"}, resp_rdata, erd);
        if (ec != 2'b00) chk({tag, " no_mem_access"}, {31'b0, saw_en}, 32'h0);
      end
    end
    if (!got) chk({tag, " timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int elat;
    logic [1:0] ec;
    logic [31:0] erd, wd, a;
    logic [2:0] f3;
    logic we;

    for (int i = 0; i < MW; i++)
      for (int b = 0; b < 4; b++) rmem[4*i + b] = init_word(i) >> (8*b);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst enables", {30'b0, d_r_en, d_w_en}, 32'h0);
    chk("rst d_add", d_add, 32'h0);
    chk("rst data_in", data_in, 32'h0);
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst err_cause", {29'b0, resp_err, resp_cause}, 32'h0);
    rst = 1'b1; preload = 1'b0;
    @(negedge clk);
    chk("rst ready", {31'b0, req_ready}, 32'h1);

    // 1: SW then LW at 0x10
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, "t1_sw");
    chk("t1 wen_c1", {31'b0, last_wen1}, 32'h1);
    chk("t1 add_c1", last_add1, 32'h4);
    do_req(0, 3'b010, 32'h10, 0, "t1_lw");
    chk("t1 lw_val", last_rd, 32'hDEADBEEF);

    // 2: sub-word loads
    do_req(0, 3'b000, 32'h13, 0, "t2_lb");  chk("t2 lb", last_rd, 32'hFFFFFFDE);
    do_req(0, 3'b100, 32'h13, 0, "t2_lbu"); chk("t2 lbu", last_rd, 32'h000000DE);
    do_req(0, 3'b001, 32'h12, 0, "t2_lh");  chk("t2 lh", last_rd, 32'hFFFFDEAD);
    do_req(0, 3'b101, 32'h12, 0, "t2_lhu"); chk("t2 lhu", last_rd, 32'h0000DEAD);

    // 3: read-modify-write
    do_req(1, 3'b000, 32'h11, 32'h55, "t3_sb");
    do_req(1, 3'b001, 32'h12, 32'h1234, "t3_sh");
    do_req(0, 3'b010, 32'h10, 0, "t3_lw");
    chk("t3 merged", last_rd, 32'h123455EF);

    // 4: errors
    do_req(0, 3'b010, 32'h12, 0, "t4_mis");   chk("t4 cause_mis", {30'b0, last_cause}, 32'h1);
    do_req(0, 3'b010, 32'(4*MW), 0, "t4_oor"); chk("t4 cause_oor", {30'b0, last_cause}, 32'h2);
    do_req(1, 3'b100, 32'h10, 0, "t4_ill");   chk("t4 cause_ill", {30'b0, last_cause}, 32'h3);

    // 5: back-to-back SW then LW with req_valid held
    wd = $urandom;
    model(1, 3'b010, 32'h40, wd, elat, ec, erd);
    model(0, 3'b010, 32'h40, 0, elat, ec, erd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = wd;
    @(negedge clk);
    chk("t5 ready_st_wr", {31'b0, req_ready}, 32'h0);
    chk("t5 wen", {31'b0, d_w_en}, 32'h1);
    @(negedge clk);
    chk("t5 sw_resp", {31'b0, resp_valid}, 32'h1);
    chk("t5 ready_resp", {31'b0, req_ready}, 32'h1);
    req_we = 1'b0;
    @(negedge clk);
    chk("t5 lw_accepted", {31'b0, d_r_en}, 32'h1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t5 no_early_resp", {31'b0, resp_valid}, 32'h0);
    @(negedge clk);
    chk("t5 lw_resp", {31'b0, resp_valid}, 32'h1);
    chk("t5 lw_data", resp_rdata, erd);

    // 6: reset during RMW_WR of SB 0x20
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'hAA;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t6 in_rmw_wr", {31'b0, d_w_en}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t6 wen_drop", {30'b0, d_w_en, d_r_en}, 32'h0);
    chk("t6 no_resp", {31'b0, resp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6 ready", {31'b0, req_ready}, 32'h1);
    chk("t6 outs", d_add | data_in | resp_rdata, 32'h0);
    chk("t6 flags", {27'b0, resp_valid, resp_err, resp_cause, d_w_en}, 32'h0);
    @(negedge clk);
    chk("t6 no_late_resp", {31'b0, resp_valid}, 32'h0);
    do_req(0, 3'b010, 32'h20, 0, "t6_lw_intact");

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'(4*MW) + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 4*MW-1));
      endcase
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'b101;
      end
      do_req(we, f3, a, $urandom, "rnd");
    end

    chk("rw_exclusive", 32'(excl_viol), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage between the execute stage and the word-addressed data memory.
- Takes one RV32 load or store per request and converts the byte address to a word index.
- Performs byte/halfword extraction with sign or zero extension for loads.
- Performs read-modify-write for SB/SH, because the memory only reads and writes whole 32-bit words.
- Detects illegal, misaligned and out-of-range accesses and answers with a one-cycle response pulse.

Parameters:
MEM_WORDS, 100, depth of the data memory in 32-bit words; word index >= MEM_WORDS is out of range.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  execute stage presents a request.
req_ready  out  1  block can accept; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32 funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  load result; 0 for stores and errors.
resp_err  out  1  request was rejected.
resp_cause  out  2  01 misaligned, 10 out of range, 11 illegal funct3, 00 no error.
d_r_en  out  1  memory read enable.
d_w_en  out  1  memory write enable.
d_add  out  32  memory word index, {2'b00, addr[31:2]}.
data_in  out  32  memory write data.
d_out  in  32  memory read data; valid only in the cycle right after the edge that sampled d_r_en=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1 once reset releases.
  - resp_valid=0, resp_rdata=0, resp_err=0, resp_cause=0.
  - d_r_en=0, d_w_en=0, d_add=0, data_in=0.
  - Asserting reset mid-operation aborts the access; enables drop immediately and no partial response is produced.
- The request is captured at the edge where req_valid && req_ready. That request cycle is cycle 0. Captured fields are held in registers until the request completes.
- Error checks are done in cycle 0, with priority illegal > misaligned > range:
  - illegal: funct3 in {011, 110, 111}, or a store with funct3[2]=1;
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0;
  - range: addr[31:2] >= MEM_WORDS.
  - On error: no memory access; resp_valid=1, resp_err=1 and cause set in cycle 1; state stays IDLE.
- State machine: IDLE, LD_RD, LD_RSP, ST_WR, RMW_RD, RMW_WR.
  - IDLE: enables low, d_add=0, data_in=0. An accepted legal request goes to LD_RD (load), ST_WR (SW) or RMW_RD (SB/SH).
  - LD_RD: d_r_en=1, d_add=word index; next state LD_RSP.
  - LD_RSP: enables low. The byte/half lane is selected from d_out by addr[1:0] and sign- or zero-extended per funct3[2]. The result is registered into resp_rdata; next state IDLE.
  - ST_WR: d_w_en=1, data_in=req_wdata; next state IDLE.
  - RMW_RD: d_r_en=1; next state RMW_WR.
  - RMW_WR: d_w_en=1. data_in is d_out with the addressed byte (addr[1:0]) or half (addr[1]) replaced by req_wdata[7:0] or req_wdata[15:0]. The merge is combinational from d_out; next state IDLE.
- Latency: resp_valid is high in cycle 1 (error), cycle 2 (SW), and cycle 3 (loads, SB, SH).
  - resp_valid is asserted in the IDLE cycle, so a new request may be accepted in the same cycle: back-to-back, no bubble.
  - resp_rdata, resp_err and resp_cause are valid only while resp_valid=1. They hold their values until the next response.
- d_r_en and d_w_en are never high in the same cycle. Outside the states listed above both are low.
- Requests presented while req_ready=0 are ignored, not queued; the upstream stage holds them.

Test Plan:
1. Reset, then SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> d_w_en with d_add=4 in cycle 1; LW resp_valid in cycle 3 with resp_rdata=0xDEADBEEF, resp_err=0.
2. Word 4 = 0xDEADBEEF; loads at addr 0x13: LB -> 0xFFFFFFDE, LBU -> 0x000000DE; LH at 0x12 -> 0xFFFFDEAD; LHU at 0x12 -> 0x0000DEAD.
3. Word 4 = 0xDEADBEEF; SB addr 0x11 data 0x55, then SH addr 0x12 data 0x1234 -> RMW_RD then RMW_WR each; final LW returns 0x12345 5EF, i.e. 0x123455EF.
4. LW addr 0x12 -> resp_err=1, cause=01 in cycle 1, no enable ever high. LW addr 4*MEM_WORDS -> cause=10. Store with funct3=100 -> cause=11.
5. Hold req_valid with SW then LW back to back -> second request accepted in the cycle SW resp_valid=1; req_ready=0 during ST_WR.
6. Drop rst to 0 during RMW_WR of SB addr 0x20 -> d_w_en falls without a clock edge, no resp_valid; after release req_ready=1 and all outputs are 0.
